// File: rtl/mopshub_hub_ctrl.sv
// MOPSHUB hub control core: power-up, trim, init, downlink routing, uplink arbitration.
// Define MOPSHUB_TMR_EN to triplicate the control registers and add the tmr_err port.
module mopshub_hub_ctrl #(
  parameter int PWR_WAIT     = 16,
  parameter int TRIM_TIMEOUT = 1024,
  parameter int RESP_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  n_buses,
  input  logic        osc_auto_trim_mopshub,
  input  logic        endwait_all,
  input  logic        trim_done,
  input  logic        dl_valid,
  input  logic [75:0] data_tra_downlink,
  output logic        dl_ready,
  input  logic [31:0] can_rx_req,
  input  logic [67:0] can_rx_data,
  output logic        can_rx_ack,
  output logic        power_bus_en,
  output logic [4:0]  power_bus_cnt,
  output logic        rst_bus,
  output logic        end_power_init,
  output logic        start_trim_ack,
  output logic        end_trim_bus,
  output logic        start_init,
  output logic        end_init,
  output logic        sign_on_sig,
  output logic [4:0]  can_tra_select,
  output logic        can_tra_valid,
  output logic [67:0] can_tra_data,
  output logic [4:0]  can_rec_select,
  output logic [75:0] data_rec_uplink,
  output logic        irq_elink_tra,
  output logic        irq_elink_rec
`ifdef MOPSHUB_TMR_EN
  ,
  output logic        tmr_err
`endif
);

  localparam int TW =
    $clog2(RESP_TIMEOUT + TRIM_TIMEOUT + PWR_WAIT) + 1;

  typedef enum logic [2:0] {
    PWR, TRIM_ACK, TRIM_WAIT, TRIM_NEXT,
    INIT, RUN, WAIT_RESP
  } state_t;

  typedef struct packed {
    logic        pwr_en;
    logic        rst_bus;
    logic        end_pwr;
    logic        trim_ack;
    logic        end_trim;
    logic        start_init;
    logic        end_init;
    logic        sign_on;
    logic        dl_ready;
    logic [4:0]  tra_sel;
    logic        tra_valid;
    logic [67:0] tra_data;
    logic [4:0]  rec_sel;
    logic [75:0] rec_data;
    logic        irq_tra;
    logic        irq_rec;
    logic        rx_ack;
  } out_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    ptr_q, ptr_d;
  logic [4:0]    target_q, target_d;
  logic          busy_q, busy_d;
  logic [4:0]    nb_q;
  out_t          out_q, out_d;

  logic [31:0]   req_m;
  logic          found;
  logic [4:0]    win;
  logic          grant;
  logic          dl_ok;

  assign power_bus_en    = out_q.pwr_en;
  assign rst_bus         = out_q.rst_bus;
  assign end_power_init  = out_q.end_pwr;
  assign start_trim_ack  = out_q.trim_ack;
  assign end_trim_bus    = out_q.end_trim;
  assign start_init      = out_q.start_init;
  assign end_init        = out_q.end_init;
  assign sign_on_sig     = out_q.sign_on;
  assign dl_ready        = out_q.dl_ready;
  assign can_tra_select  = out_q.tra_sel;
  assign can_tra_valid   = out_q.tra_valid;
  assign can_tra_data    = out_q.tra_data;
  assign can_rec_select  = out_q.rec_sel;
  assign data_rec_uplink = out_q.rec_data;
  assign irq_elink_tra   = out_q.irq_tra;
  assign irq_elink_rec   = out_q.irq_rec;
  assign can_rx_ack      = out_q.rx_ack;
  assign power_bus_cnt   = cnt_q;

  // Round-robin search starting one past the last grant; masked
  // requests above n_buses make the mod-32 walk wrap at n_buses.
  always_comb begin
    logic [4:0] idx;
    req_m = can_rx_req & ((32'd2 << nb_q) - 32'd1);
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= 32; i++) begin
      idx = ptr_q + 5'(i);
      if (!found && req_m[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant = found && !busy_q &&
            (state_q == RUN || state_q == WAIT_RESP);
    dl_ok = (data_tra_downlink[75:73] == 3'b000) &&
            (data_tra_downlink[72:68] <= nb_q);
  end

  // Phase sequencing, downlink routing, uplink capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    busy_d   = 1'b0;
    out_d    = out_q;
    out_d.end_pwr    = 1'b0;
    out_d.trim_ack   = 1'b0;
    out_d.end_trim   = 1'b0;
    out_d.start_init = 1'b0;
    out_d.end_init   = 1'b0;
    out_d.sign_on    = 1'b0;
    out_d.tra_valid  = 1'b0;
    out_d.irq_tra    = 1'b0;
    out_d.irq_rec    = 1'b0;
    out_d.rx_ack     = 1'b0;

    unique case (state_q)
      PWR: begin
        if (timer_q == TW'(PWR_WAIT - 1)) begin
          timer_d = '0;
          if (cnt_q == nb_q) begin
            out_d.end_pwr = 1'b1;
            cnt_d = '0;
            state_d = osc_auto_trim_mopshub ?
                      TRIM_ACK : INIT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      TRIM_ACK: begin
        out_d.trim_ack = 1'b1;
        timer_d = '0;
        state_d = TRIM_WAIT;
      end
      TRIM_WAIT: begin
        if (trim_done ||
            timer_q == TW'(TRIM_TIMEOUT - 1)) begin
          out_d.end_trim = 1'b1;
          state_d = TRIM_NEXT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      TRIM_NEXT: begin
        if (cnt_q == nb_q) begin
          cnt_d = '0;
          timer_d = '0;
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 5'd1;
          state_d = TRIM_ACK;
        end
      end
      INIT: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(0)) out_d.start_init = 1'b1;
        if (timer_q == TW'(2)) out_d.end_init = 1'b1;
        if (timer_q == TW'(3)) begin
          out_d.sign_on = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dl_valid && out_q.dl_ready && dl_ok) begin
          out_d.tra_sel   = data_tra_downlink[72:68];
          out_d.tra_data  = data_tra_downlink[67:0];
          out_d.tra_valid = 1'b1;
          out_d.irq_tra   = 1'b1;
          target_d = data_tra_downlink[72:68];
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (endwait_all ||
            (grant && win == target_q) ||
            timer_q == TW'(RESP_TIMEOUT - 1)) begin
          state_d = RUN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = PWR;
    endcase

    if (grant) begin
      out_d.rec_sel = win;
      ptr_d = win;
      busy_d = 1'b1;
    end
    if (busy_q) begin
      out_d.rec_data = {3'b000, out_q.rec_sel, can_rx_data};
      out_d.irq_rec = 1'b1;
      out_d.rx_ack = 1'b1;
    end

    out_d.pwr_en   = (state_d == PWR);
    out_d.rst_bus  = (state_d == PWR);
    out_d.dl_ready = (state_d == RUN);
  end

  // Output and bookkeeping registers; n_buses is held from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_q.rst_bus <= 1'b1;
      target_q <= '0;
      busy_q <= 1'b0;
      nb_q <= n_buses;
    end else begin
      out_q <= out_d;
      target_q <= target_d;
      busy_q <= busy_d;
    end
  end

`ifdef MOPSHUB_TMR_EN
  state_t        st_r  [3];
  logic [4:0]    cnt_r [3];
  logic [TW-1:0] tim_r [3];
  logic [4:0]    ptr_r [3];

  function automatic logic [TW-1:0] maj3(
    input logic [TW-1:0] a,
    input logic [TW-1:0] b,
    input logic [TW-1:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Three copies all reload from the voted next value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        st_r[i]  <= PWR;
        cnt_r[i] <= '0;
        tim_r[i] <= '0;
        ptr_r[i] <= 5'd31;
      end else begin
        st_r[i]  <= state_d;
        cnt_r[i] <= cnt_d;
        tim_r[i] <= timer_d;
        ptr_r[i] <= ptr_d;
      end
    end
  end

  assign state_q = state_t'(3'(maj3(
    TW'(st_r[0]), TW'(st_r[1]), TW'(st_r[2]))));
  assign cnt_q = 5'(maj3(
    TW'(cnt_r[0]), TW'(cnt_r[1]), TW'(cnt_r[2])));
  assign timer_q = maj3(tim_r[0], tim_r[1], tim_r[2]);
  assign ptr_q = 5'(maj3(
    TW'(ptr_r[0]), TW'(ptr_r[1]), TW'(ptr_r[2])));

  assign tmr_err =
    (st_r[0] != st_r[1]) || (st_r[1] != st_r[2]) ||
    (cnt_r[0] != cnt_r[1]) || (cnt_r[1] != cnt_r[2]) ||
    (tim_r[0] != tim_r[1]) || (tim_r[1] != tim_r[2]) ||
    (ptr_r[0] != ptr_r[1]) || (ptr_r[1] != ptr_r[2]);
`else
  // Single control registers; pointer starts at 31 so bus 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWR;
      cnt_q   <= '0;
      timer_q <= '0;
      ptr_q   <= 5'd31;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mopshub_hub_ctrl.sv
// Directed bench for mopshub_hub_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mopshub_hub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  n_buses;
  logic        osc;
  logic        endwait_all;
  logic        trim_done;
  logic        dl_valid;
  logic [75:0] dl_data;
  logic        dl_ready;
  logic [31:0] req;
  logic [67:0] rx_data;
  logic        rx_ack;
  logic        pwr_en;
  logic [4:0]  pwr_cnt;
  logic        rst_bus;
  logic        end_pwr, trim_ack, end_trim;
  logic        st_init, en_init, sign_on;
  logic [4:0]  tra_sel;
  logic        tra_valid;
  logic [67:0] tra_data;
  logic [4:0]  rec_sel;
  logic [75:0] rec_data;
  logic        irq_tra, irq_rec;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // The bus model returns a payload tagged with its own index.
  assign rx_data = 68'h5A0 + 68'(rec_sel);

  mopshub_hub_ctrl dut (
    .clk(clk), .rst(rst), .n_buses(n_buses),
    .osc_auto_trim_mopshub(osc),
    .endwait_all(endwait_all), .trim_done(trim_done),
    .dl_valid(dl_valid), .data_tra_downlink(dl_data),
    .dl_ready(dl_ready), .can_rx_req(req),
    .can_rx_data(rx_data), .can_rx_ack(rx_ack),
    .power_bus_en(pwr_en), .power_bus_cnt(pwr_cnt),
    .rst_bus(rst_bus), .end_power_init(end_pwr),
    .start_trim_ack(trim_ack), .end_trim_bus(end_trim),
    .start_init(st_init), .end_init(en_init),
    .sign_on_sig(sign_on),
    .can_tra_select(tra_sel), .can_tra_valid(tra_valid),
    .can_tra_data(tra_data), .can_rec_select(rec_sel),
    .data_rec_uplink(rec_data),
    .irq_elink_tra(irq_tra), .irq_elink_rec(irq_rec)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [75:0] obs,
                     input logic [75:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] g_exp [4];
    int t;
    g_exp = '{5'd0, 5'd1, 5'd3, 5'd0};
    rst = 1'b1; n_buses = 5'd3; osc = 1'b0;
    endwait_all = 1'b0; trim_done = 1'b0;
    dl_valid = 1'b0; dl_data = '0; req = '0;
    repeat (2) step();
    chk("rst_rst_bus", 76'(rst_bus), 76'(1));
    chk("rst_pwr_en", 76'(pwr_en), 76'(0));
    chk("rst_cnt", 76'(pwr_cnt), 76'(0));
    chk("rst_dl_ready", 76'(dl_ready), 76'(0));
    chk("rst_tra_valid", 76'(tra_valid), 76'(0));
    chk("rst_rec_data", rec_data, 76'(0));
    rst = 1'b0;

    repeat (16) step();
    chk("pwr_cnt16", 76'(pwr_cnt), 76'(1));
    chk("pwr_en16", 76'(pwr_en), 76'(1));
    chk("pwr_rst_bus16", 76'(rst_bus), 76'(1));
    repeat (16) step();
    chk("pwr_cnt32", 76'(pwr_cnt), 76'(2));
    repeat (16) step();
    chk("pwr_cnt48", 76'(pwr_cnt), 76'(3));
    repeat (15) step();
    chk("end_pwr63", 76'(end_pwr), 76'(0));
    step();
    chk("end_pwr64", 76'(end_pwr), 76'(1));
    chk("rst_bus64", 76'(rst_bus), 76'(0));
    chk("trim_ack_off", 76'(trim_ack), 76'(0));
    step();
    chk("start_init", 76'(st_init), 76'(1));
    step();
    chk("end_init_early", 76'(en_init), 76'(0));
    step();
    chk("end_init", 76'(en_init), 76'(1));
    step();
    chk("sign_on", 76'(sign_on), 76'(1));
    chk("run_dl_ready", 76'(dl_ready), 76'(1));
    step();
    chk("sign_on_pulse", 76'(sign_on), 76'(0));

    req = 32'b1011;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("arb_grant", 76'(rec_sel), 76'(g_exp[k]));
      chk("arb_irq_gap", 76'(irq_rec), 76'(0));
      step();
      chk("arb_irq", 76'(irq_rec), 76'(1));
      chk("arb_ack", 76'(rx_ack), 76'(1));
      chk("arb_data", rec_data,
          {3'b000, g_exp[k], 68'h5A0 + 68'(g_exp[k])});
    end
    req = 32'h10;
    repeat (4) step();
    chk("arb_above_nb", 76'(irq_rec), 76'(0));
    chk("arb_above_sel", 76'(rec_sel), 76'(0));
    req = '0;

    dl_data = {8'h02, 68'hABC}; dl_valid = 1'b1;
    step();
    dl_valid = 1'b0;
    chk("dl_valid", 76'(tra_valid), 76'(1));
    chk("dl_irq", 76'(irq_tra), 76'(1));
    chk("dl_sel", 76'(tra_sel), 76'(2));
    chk("dl_data", 76'(tra_data), 76'(68'hABC));
    chk("dl_ready_drop", 76'(dl_ready), 76'(0));
    step();
    chk("dl_valid_pulse", 76'(tra_valid), 76'(0));
    repeat (5) step();
    chk("dl_wait", 76'(dl_ready), 76'(0));
    req = 32'h4;
    step();
    chk("resp_grant", 76'(rec_sel), 76'(2));
    chk("resp_ready", 76'(dl_ready), 76'(1));
    step();
    req = '0;
    chk("resp_data", rec_data, {3'b000, 5'd2, 68'h5A2});
    step();
    chk("resp_irq_end", 76'(irq_rec), 76'(0));

    dl_data = {8'h01, 68'h123}; dl_valid = 1'b1;
    req = 32'h1;
    step();
    dl_valid = 1'b0;
    chk("sim_dl_valid", 76'(tra_valid), 76'(1));
    chk("sim_dl_sel", 76'(tra_sel), 76'(1));
    chk("sim_up_grant", 76'(rec_sel), 76'(0));
    step();
    req = '0;
    chk("sim_up_data", rec_data, {3'b000, 5'd0, 68'h5A0});
    repeat (97) step();
    chk("ew_wait99", 76'(dl_ready), 76'(0));
    endwait_all = 1'b1;
    step();
    endwait_all = 1'b0;
    chk("ew_release", 76'(dl_ready), 76'(1));

    dl_data = {8'h01, 68'h77}; dl_valid = 1'b1;
    step();
    dl_valid = 1'b0;
    chk("to_accept", 76'(tra_valid), 76'(1));
    repeat (4095) step();
    chk("to_4095", 76'(dl_ready), 76'(0));
    step();
    chk("to_4096", 76'(dl_ready), 76'(1));

    dl_data = {8'h25, 68'h1}; dl_valid = 1'b1;
    step();
    chk("drop25_valid", 76'(tra_valid), 76'(0));
    chk("drop25_irq", 76'(irq_tra), 76'(0));
    chk("drop25_ready", 76'(dl_ready), 76'(1));
    dl_data = {8'h05, 68'h1};
    step();
    dl_valid = 1'b0;
    chk("drop05_valid", 76'(tra_valid), 76'(0));
    chk("drop05_ready", 76'(dl_ready), 76'(1));
    dl_data = {8'h03, 68'h9}; dl_valid = 1'b1;
    step();
    dl_valid = 1'b0;
    chk("edge_nb_valid", 76'(tra_valid), 76'(1));
    chk("edge_nb_sel", 76'(tra_sel), 76'(3));

    rst = 1'b1;
    step();
    chk("mid_rst_bus", 76'(rst_bus), 76'(1));
    chk("mid_rst_cnt", 76'(pwr_cnt), 76'(0));
    chk("mid_rst_ready", 76'(dl_ready), 76'(0));
    osc = 1'b1;
    rst = 1'b0;
    step();
    chk("restart_pwr_en", 76'(pwr_en), 76'(1));
    chk("restart_cnt", 76'(pwr_cnt), 76'(0));
    repeat (63) step();
    chk("trim_end_pwr", 76'(end_pwr), 76'(1));
    step();
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (!trim_ack && t < 50) begin
        step();
        t++;
      end
      chk("trim_ack", 76'(trim_ack), 76'(1));
      chk("trim_ack_cnt", 76'(pwr_cnt), 76'(b));
      if (b < 3) begin
        repeat (10) step();
        trim_done = 1'b1;
        step();
        trim_done = 1'b0;
        chk("trim_end", 76'(end_trim), 76'(1));
        chk("trim_end_cnt", 76'(pwr_cnt), 76'(b));
      end else begin
        repeat (1023) step();
        chk("trim_to_1023", 76'(end_trim), 76'(0));
        step();
        chk("trim_to_1024", 76'(end_trim), 76'(1));
      end
    end
    t = 0;
    while (!st_init && t < 20) begin
      step();
      t++;
    end
    chk("trim_start_init", 76'(st_init), 76'(1));
    t = 0;
    while (!sign_on && t < 20) begin
      step();
      t++;
    end
    chk("trim_sign_on", 76'(sign_on), 76'(1));
    chk("trim_dl_ready", 76'(dl_ready), 76'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mopshub_hub_ctrl.md
Name: mopshub_hub_ctrl

Overview:
- Central control core of the MOPSHUB hub.
- Power-up sequence: powers the CAN buses one by one, optionally trims each bus's oscillator, runs one init/sign-on step, then enters run mode.
- In run mode it routes 76-bit downlink frames from the e-link side to a selected CAN bus, and arbitrates uplink frames from up to 32 buses back to the e-link side with interrupts.
- Sits between the e-link serializer and the per-bus CAN controllers.

Parameters:
- PWR_WAIT, 16, clock cycles each bus stays in power-settle (rst_bus high) before advancing.
- TRIM_TIMEOUT, 1024, maximum cycles waited for trim_done per bus.
- RESP_TIMEOUT, 4096, maximum cycles waited for a bus response after a downlink frame.

Ports:
- clk  in  1  system clock (40 MHz)
- rst  in  1  synchronous, active-high reset
- n_buses  in  5  highest bus index in use (0..31); sampled at reset release
- osc_auto_trim_mopshub  in  1  1 = run trim phase
- endwait_all  in  1  abort any pending response wait
- trim_done  in  1  pulse from the bus under trim
- dl_valid  in  1  downlink frame strobe
- data_tra_downlink  in  76  downlink frame: [75:68] bus_id, [67:0] CAN payload
- dl_ready  out  1  ready for a downlink frame
- can_rx_req  in  32  per-bus uplink frame pending
- can_rx_data  in  68  payload of the bus addressed by can_rec_select
- can_rx_ack  out  1  pulse: can_rec_select bus frame consumed
- power_bus_en  out  1  power phase active
- power_bus_cnt  out  5  bus currently powered/trimmed
- rst_bus  out  1  reset to the bus at power_bus_cnt
- end_power_init, start_trim_ack, end_trim_bus, start_init, end_init, sign_on_sig  out  1 each  single-cycle phase pulses
- can_tra_select  out  5  downlink target bus
- can_tra_valid  out  1  pulse: frame presented to bus
- can_tra_data  out  68  payload to bus
- can_rec_select  out  5  uplink bus granted
- data_rec_uplink  out  76  {3'b0, bus id[4:0], payload}
- irq_elink_tra, irq_elink_rec  out  1  pulses on frame sent / received

Behaviour:
- Reset: all outputs 0 except dl_ready=0 and rst_bus=1. State = PWR and power_bus_cnt = 0.
- PWR:
  - power_bus_en=1; rst_bus=1 for PWR_WAIT cycles on the current bus.
  - power_bus_cnt then increments.
  - When power_bus_cnt == n_buses completes: end_power_init pulses and rst_bus=0.
  - Next state is TRIM if osc_auto_trim_mopshub=1, else INIT.
- TRIM, per bus 0..n_buses:
  - start_trim_ack pulses with power_bus_cnt = bus.
  - Wait for trim_done or TRIM_TIMEOUT; either pulses end_trim_bus for one cycle and advances.
  - After the last bus, go to INIT.
- INIT: start_init pulses; end_init pulses 2 cycles later; sign_on_sig pulses the next cycle. Then RUN with dl_ready=1.
- RUN, downlink:
  - dl_valid && dl_ready: the next cycle drives can_tra_select = data[72:68], can_tra_data = data[67:0], can_tra_valid=1, irq_elink_tra=1.
  - dl_ready drops; state WAIT_RESP.
  - bus_id[7:5] != 0 or bus_id > n_buses: frame dropped, no pulses, dl_ready stays 1.
- WAIT_RESP:
  - Exits to RUN when can_rx_req[target] is taken by the arbiter, on RESP_TIMEOUT, or on endwait_all (highest priority).
  - dl_ready reasserts the cycle after exit.
- Uplink arbitration (RUN and WAIT_RESP):
  - Round-robin over can_rx_req[n_buses:0], searching from last grant+1 and wrapping to 0.
  - Grant cycle: can_rec_select = winner.
  - Next cycle: capture can_rx_data into data_rec_uplink; pulse irq_elink_rec and can_rx_ack.
  - At most one uplink frame per 2 cycles. Requests above n_buses are ignored.
  - Simultaneous downlink accept and uplink grant are both served.
- dl_valid is ignored outside RUN.
- rst mid-operation restarts from PWR with bus 0.

Optional Feature:
- MOPSHUB_TMR_EN defined:
  - State register, power_bus_cnt, timers and the arbiter pointer are triplicated.
  - Each is updated from a 2-of-3 majority vote every cycle, so a single upset register self-corrects in 1 cycle.
  - Output tmr_err (1 bit, added port) pulses when any vote disagrees.
- MOPSHUB_TMR_EN undefined: single registers, no tmr_err port. Functional behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, n_buses=3, trim off, PWR_WAIT=16 -> power_bus_cnt steps 0..3 every 16 cycles; end_power_init at cycle 64; start_init, end_init, then sign_on_sig; dl_ready=1.
- Trim on, trim_done returned 10 cycles after each start_trim_ack -> 4 start_trim_ack/end_trim_bus pairs with power_bus_cnt 0..3, then INIT.
- RUN, data_tra_downlink={8'h02, 68'hABC} -> can_tra_select=2, can_tra_data=68'hABC, can_tra_valid and irq_elink_tra pulse 1 cycle later; dl_ready=0 until can_rx_req[2] is granted.
- can_rx_req=4'b1011 held -> grants in order 0, 1, 3, 0; data_rec_uplink[72:68] matches each grant; irq_elink_rec pulses every 2 cycles.
- Downlink to bus 1 with no response, endwait_all pulse at cycle 100 -> dl_ready=1 the next cycle; no timeout at 4096.
- Downlink bus_id 8'h25 -> dropped, no can_tra_valid; rst asserted mid-RUN -> state PWR, rst_bus=1, power_bus_cnt=0.
